// File: rtl/ps2_scan_sequencer.sv
// PS/2 frame capture, start/parity/stop check, E0/F0 prefix folding and round-robin slot write scheduling.
// Latency: results registered on the stop-bit edge (edge 10); no backpressure, every pulse lasts one ps2Clk cycle.
module ps2_scan_sequencer #(
    parameter int IGNORE_REPEAT = 1
) (
    input  logic       ps2Clk,
    input  logic       reset,
    input  logic       ps2Data,
    output logic [7:0] scancode,
    output logic       ext,
    output logic       brk,
    output logic       code_valid,
    output logic       frame_err,
    output logic [2:0] slot_we,
    output logic [7:0] slot_data,
    output logic       busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic [1:0] state;
    logic [2:0] bit_cnt;
    logic       par_acc;
    logic       par_ok;
    logic [7:0] sh;
    logic       ext_pend;
    logic       brk_pend;
    logic [1:0] wr_ptr;
    logic [7:0] last_make;
    logic       last_make_vld;
    logic       repeat_hit;

    assign busy       = (state != IDLE);
    assign repeat_hit = (IGNORE_REPEAT != 0) && last_make_vld && (sh == last_make);

    always_ff @(posedge ps2Clk) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= 3'd0;
            par_acc       <= 1'b0;
            par_ok        <= 1'b0;
            sh            <= 8'h00;
            ext_pend      <= 1'b0;
            brk_pend      <= 1'b0;
            wr_ptr        <= 2'd0;
            last_make     <= 8'h00;
            last_make_vld <= 1'b0;
            scancode      <= 8'h00;
            ext           <= 1'b0;
            brk           <= 1'b0;
            code_valid    <= 1'b0;
            frame_err     <= 1'b0;
            slot_we       <= 3'b000;
            slot_data     <= 8'h00;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            slot_we    <= 3'b000;
            case (state)
                IDLE: begin
                    if (!ps2Data) begin
                        state   <= DATA;
                        bit_cnt <= 3'd0;
                        par_acc <= 1'b0;
                    end
                end
                DATA: begin
                    sh      <= {ps2Data, sh[7:1]};
                    par_acc <= par_acc ^ ps2Data;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state <= PARITY;
                    end
                end
                PARITY: begin
                    par_ok <= par_acc ^ ps2Data;
                    state  <= STOP;
                end
                STOP: begin
                    state <= IDLE;
                    if (ps2Data && par_ok) begin
                        if (sh == 8'hE0) begin
                            ext_pend <= 1'b1;
                        end else if (sh == 8'hF0) begin
                            brk_pend <= 1'b1;
                        end else begin
                            scancode   <= sh;
                            ext        <= ext_pend;
                            brk        <= brk_pend;
                            code_valid <= 1'b1;
                            ext_pend   <= 1'b0;
                            brk_pend   <= 1'b0;
                            // Break codes never occupy a slot but re-arm repeat detection.
                            if (brk_pend) begin
                                last_make_vld <= 1'b0;
                            end else if (!repeat_hit) begin
                                slot_we       <= 3'b001 << wr_ptr;
                                slot_data     <= sh;
                                wr_ptr        <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
                                last_make     <= sh;
                                last_make_vld <= 1'b1;
                            end
                        end
                    end else begin
                        frame_err <= 1'b1;
                        ext_pend  <= 1'b0;
                        brk_pend  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Bench for ps2_scan_sequencer: directed scenarios plus randomized frame streams against a reference model.
module tb_ps2_scan_sequencer;

    logic       ps2Clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2Data = 1'b1;
    logic [7:0] scancode;
    logic       ext;
    logic       brk;
    logic       code_valid;
    logic       frame_err;
    logic [2:0] slot_we;
    logic [7:0] slot_data;
    logic       busy;

    int tests = 0;
    int fails = 0;

    ps2_scan_sequencer #(.IGNORE_REPEAT(1)) dut (
        .ps2Clk     (ps2Clk),
        .reset      (reset),
        .ps2Data    (ps2Data),
        .scancode   (scancode),
        .ext        (ext),
        .brk        (brk),
        .code_valid (code_valid),
        .frame_err  (frame_err),
        .slot_we    (slot_we),
        .slot_data  (slot_data),
        .busy       (busy)
    );

    always #5 ps2Clk = ~ps2Clk;

    // Reference model: tracks decoded outputs at whole-frame granularity.
    bit         m_ext_p, m_brk_p;
    int         m_ptr;
    int         m_last;
    logic [7:0] exp_sc, exp_sd;
    logic       exp_ext, exp_brk, exp_cv, exp_fe;
    logic [2:0] exp_we;

    logic [10:0] busy_trace;
    logic        pulse_at0;
    localparam logic [10:0] BUSY_EXP = 11'b011_1111_1111;

    task automatic model_reset();
        m_ext_p = 0; m_brk_p = 0; m_ptr = 0; m_last = -1;
        exp_sc = 8'h00; exp_sd = 8'h00; exp_ext = 0; exp_brk = 0;
        exp_cv = 0; exp_fe = 0; exp_we = 3'b000;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit good);
        exp_cv = 0; exp_fe = 0; exp_we = 3'b000;
        if (!good) begin
            exp_fe = 1; m_ext_p = 0; m_brk_p = 0;
        end else if (b == 8'hE0) begin
            m_ext_p = 1;
        end else if (b == 8'hF0) begin
            m_brk_p = 1;
        end else begin
            exp_cv = 1; exp_sc = b; exp_ext = m_ext_p; exp_brk = m_brk_p;
            if (m_brk_p) begin
                m_last = -1;
            end else if (m_last != int'(b)) begin
                exp_we = 3'(1 << m_ptr);
                exp_sd = b;
                m_ptr  = (m_ptr + 1) % 3;
                m_last = int'(b);
            end
            m_ext_p = 0; m_brk_p = 0;
        end
    endtask

    // Drives one 11-bit frame; leaves time #1 after edge 10.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop);
        logic [10:0] bits;
        bits = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int k = 0; k < 11; k++) begin
            ps2Data = bits[k];
            @(posedge ps2Clk);
            #1;
            busy_trace[k] = busy;
            if (k == 0) pulse_at0 = code_valid | frame_err | (|slot_we);
        end
        model_frame(b, !bad_par && (stop == 1'b1));
    endtask

    task automatic idle(input int n);
        ps2Data = 1'b1;
        repeat (n) begin
            @(posedge ps2Clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        tests++;
        if ({scancode, ext, brk, code_valid, frame_err, slot_we, slot_data, busy} !== 23'd0) begin
            fails++;
            $display("FAIL reset_values: got sc=%h ext=%b brk=%b cv=%b fe=%b we=%b sd=%h busy=%b, want all 0",
                     scancode, ext, brk, code_valid, frame_err, slot_we, slot_data, busy);
        end
        reset = 1'b0;
        model_reset();
        idle(2);
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_make();
        send_frame(8'h1C, 0, 1'b1);
        tests++;
        if (code_valid !== 1'b1 || frame_err !== 1'b0) begin
            fails++; $display("FAIL make_pulse: cv=%b fe=%b want cv=1 fe=0", code_valid, frame_err);
        end
        tests++;
        if (scancode !== 8'h1C || ext !== 1'b0 || brk !== 1'b0) begin
            fails++; $display("FAIL make_code: sc=%h ext=%b brk=%b want 1c 0 0", scancode, ext, brk);
        end
        tests++;
        if (slot_we !== 3'b001 || slot_data !== 8'h1C) begin
            fails++; $display("FAIL make_slot: we=%b sd=%h want 001 1c", slot_we, slot_data);
        end
        tests++;
        if (busy_trace !== BUSY_EXP) begin
            fails++; $display("FAIL make_busy: trace=%b want %b", busy_trace, BUSY_EXP);
        end
        idle(1);
        tests++;
        if (code_valid !== 1'b0 || slot_we !== 3'b000) begin
            fails++; $display("FAIL make_pulse_width: cv=%b we=%b want 0 000 at edge 11", code_valid, slot_we);
        end
    endtask

    task automatic test_break();
        send_frame(8'hF0, 0, 1'b1);
        tests++;
        if (code_valid !== 1'b0 || slot_we !== 3'b000) begin
            fails++; $display("FAIL break_prefix: cv=%b we=%b want 0 000", code_valid, slot_we);
        end
        send_frame(8'h1C, 0, 1'b1);
        tests++;
        if (code_valid !== 1'b1 || brk !== 1'b1 || ext !== 1'b0 || scancode !== 8'h1C || slot_we !== 3'b000) begin
            fails++; $display("FAIL break_code: cv=%b brk=%b ext=%b sc=%h we=%b want 1 1 0 1c 000",
                              code_valid, brk, ext, scancode, slot_we);
        end
    endtask

    task automatic test_ext_break();
        send_frame(8'hE0, 0, 1'b1);
        send_frame(8'hF0, 0, 1'b1);
        send_frame(8'h75, 0, 1'b1);
        tests++;
        if (code_valid !== 1'b1 || ext !== 1'b1 || brk !== 1'b1 || scancode !== 8'h75 || slot_we !== 3'b000) begin
            fails++; $display("FAIL ext_break: cv=%b ext=%b brk=%b sc=%h we=%b want 1 1 1 75 000",
                              code_valid, ext, brk, scancode, slot_we);
        end
        idle(2);
        send_frame(8'h74, 0, 1'b1);
        tests++;
        if (ext !== 1'b0 || brk !== 1'b0 || slot_we !== 3'b010) begin
            fails++; $display("FAIL pend_cleared: ext=%b brk=%b we=%b want 0 0 010", ext, brk, slot_we);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] codes [5];
        logic [2:0] want_we [5];
        codes   = '{8'h1C, 8'h1C, 8'h32, 8'h21, 8'h23};
        want_we = '{3'b001, 3'b000, 3'b010, 3'b100, 3'b001};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_frame(codes[i], 0, 1'b1);
            tests++;
            if (slot_we !== want_we[i] || (want_we[i] != 3'b000 && slot_data !== codes[i])) begin
                fails++; $display("FAIL repeat_seq[%0d]: we=%b sd=%h want %b %h", i, slot_we, slot_data, want_we[i], codes[i]);
            end
            tests++;
            if (i > 0 && pulse_at0 !== 1'b0) begin
                fails++; $display("FAIL b2b_pulse_low[%0d]: pulse at edge 11 = %b want 0", i, pulse_at0);
            end
        end
    endtask

    task automatic test_errors();
        logic [7:0] sc_before;
        sc_before = scancode;
        send_frame(8'h1C, 1, 1'b1);
        tests++;
        if (frame_err !== 1'b1 || code_valid !== 1'b0 || scancode !== sc_before || slot_we !== 3'b000) begin
            fails++; $display("FAIL parity_err: fe=%b cv=%b sc=%h we=%b want 1 0 %h 000",
                              frame_err, code_valid, scancode, slot_we, sc_before);
        end
        send_frame(8'h1C, 0, 1'b0);
        tests++;
        if (frame_err !== 1'b1 || code_valid !== 1'b0 || scancode !== sc_before) begin
            fails++; $display("FAIL stop_err: fe=%b cv=%b sc=%h want 1 0 %h", frame_err, code_valid, scancode, sc_before);
        end
        idle(1);
        tests++;
        if (frame_err !== 1'b0) begin
            fails++; $display("FAIL err_pulse_width: fe=%b want 0", frame_err);
        end
        send_frame(8'hE0, 0, 1'b1);
        send_frame(8'h55, 1, 1'b1);
        send_frame(8'h1B, 0, 1'b1);
        tests++;
        if (code_valid !== 1'b1 || ext !== 1'b0 || scancode !== 8'h1B) begin
            fails++; $display("FAIL err_clears_pend: cv=%b ext=%b sc=%h want 1 0 1b", code_valid, ext, scancode);
        end
    endtask

    task automatic test_mid_reset();
        logic       saw_pulse;
        logic [5:0] part;
        part = {5'b01101, 1'b0};
        for (int k = 0; k < 6; k++) begin
            ps2Data = part[k];
            @(posedge ps2Clk);
            #1;
        end
        reset = 1'b1;
        ps2Data = 1'b1;
        @(posedge ps2Clk);
        #1;
        tests++;
        if ({scancode, ext, brk, code_valid, frame_err, slot_we, slot_data, busy} !== 23'd0) begin
            fails++; $display("FAIL mid_reset_values: sc=%h cv=%b fe=%b we=%b busy=%b want all 0",
                              scancode, code_valid, frame_err, slot_we, busy);
        end
        reset = 1'b0;
        model_reset();
        saw_pulse = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge ps2Clk);
            #1;
            saw_pulse |= code_valid | frame_err | (|slot_we) | busy;
        end
        tests++;
        if (saw_pulse !== 1'b0) begin
            fails++; $display("FAIL mid_reset_no_pulse: activity=%b want 0", saw_pulse);
        end
        send_frame(8'h2B, 0, 1'b1);
        tests++;
        if (code_valid !== 1'b1 || scancode !== 8'h2B || slot_we !== 3'b001 || slot_data !== 8'h2B) begin
            fails++; $display("FAIL mid_reset_recover: cv=%b sc=%h we=%b sd=%h want 1 2b 001 2b",
                              code_valid, scancode, slot_we, slot_data);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [6];
        logic [7:0] b;
        bit         bad_par;
        logic       stop;
        int         r;
        pool = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h15, 8'h6B};
        do_reset();
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 99);
            if (r < 20) b = 8'hE0;
            else if (r < 35) b = 8'hF0;
            else if (r < 40) b = 8'($urandom);
            else b = pool[$urandom_range(0, 5)];
            r = $urandom_range(0, 99);
            bad_par = (r < 6);
            stop    = (r >= 6 && r < 11) ? 1'b0 : 1'b1;
            send_frame(b, bad_par, stop);
            tests++;
            if (code_valid !== exp_cv || frame_err !== exp_fe || slot_we !== exp_we) begin
                fails++; $display("FAIL rand_pulses[%0d]: cv=%b fe=%b we=%b want %b %b %b",
                                  i, code_valid, frame_err, slot_we, exp_cv, exp_fe, exp_we);
            end
            tests++;
            if (scancode !== exp_sc || ext !== exp_ext || brk !== exp_brk || slot_data !== exp_sd) begin
                fails++; $display("FAIL rand_data[%0d]: sc=%h ext=%b brk=%b sd=%h want %h %b %b %h",
                                  i, scancode, ext, brk, slot_data, exp_sc, exp_ext, exp_brk, exp_sd);
            end
            tests++;
            if (busy_trace !== BUSY_EXP || pulse_at0 !== 1'b0) begin
                fails++; $display("FAIL rand_timing[%0d]: busy=%b p0=%b want %b 0", i, busy_trace, pulse_at0, BUSY_EXP);
            end
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
    endtask

    initial begin
        model_reset();
        busy_trace = '0;
        pulse_at0  = 1'b0;
        #1;
        test_reset();
        test_make();
        test_break();
        test_ext_break();
        test_back_to_back();
        test_errors();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_scan_sequencer.md
# ps2_scan_sequencer

Frame-level controller for the PS/2 keyboard receive path, running entirely in the `ps2Clk` domain. It does four things:
- sequences bit capture of each 11-bit PS/2 frame;
- validates start, odd parity and stop;
- folds `E0`/`F0` prefix bytes into extended/break flags on the following scancode;
- schedules accepted make codes round-robin into three key slots that feed the HEX display decoders.

It replaces ad-hoc per-slot enable generation with a single sequencer that owns the slot write enables.

## Interface
Parameters:
- `IGNORE_REPEAT`, default 1: when 1, a make code equal to the last slot-written make code, with no break in between, is not re-written (suppresses typematic repeat).

Ports:
- `ps2Clk` input 1: block clock; every rising edge is one PS/2 bit time.
- `reset` input 1: synchronous, active-high; clock `ps2Clk`.
- `ps2Data` input 1: PS/2 data line, sampled on each rising edge of `ps2Clk`.
- `scancode` output 8: last completed non-prefix code.
- `ext` output 1: `scancode` was preceded by `E0`.
- `brk` output 1: `scancode` was preceded by `F0`.
- `code_valid` output 1: one-cycle pulse; `scancode`/`ext`/`brk` are new.
- `frame_err` output 1: one-cycle pulse; frame discarded (parity or stop failure).
- `slot_we` output 3: one-hot slot write enable, one-cycle pulse.
- `slot_data` output 8: code to write into the slot selected by `slot_we`.
- `busy` output 1: high while a frame is in progress (state other than IDLE).

## Operation
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: `ps2Data`=0 → DATA, with `bit_cnt`=0 and `par_acc`=0; `ps2Data`=1 → stay.
  - DATA: shift `ps2Data` into `sh[7:0]` LSB first (new bit enters `sh[7]`, shift right); XOR it into `par_acc`; increment `bit_cnt` (3-bit). After the 8th bit (`bit_cnt`=7) → PARITY.
  - PARITY: store `par_ok = par_acc ^ ps2Data` (1 = odd parity correct) → STOP.
  - STOP: frame good iff `ps2Data`=1 and `par_ok`=1; → IDLE in all cases.
- Good frame handling:
  - byte `E0`: set `ext_pend`; no pulse.
  - byte `F0`: set `brk_pend`; no pulse.
  - any other byte: drive `scancode`=byte, `ext`=`ext_pend`, `brk`=`brk_pend`; pulse `code_valid`; clear both pend flags.
- Bad frame: pulse `frame_err`; clear `ext_pend` and `brk_pend`; `scancode`/`ext`/`brk` hold their values.
- Slot scheduler, with 2-bit `wr_ptr` (0,1,2) and `last_make` (8-bit) plus a valid flag:
  - make code (`brk_pend`=0 at emission):
    - if `IGNORE_REPEAT`=0, or code ≠ `last_make`, or `last_make` is invalid: pulse `slot_we[wr_ptr]`, drive `slot_data`=code, advance `wr_ptr` 2→0 wrap, set `last_make`=code and mark it valid;
    - otherwise (suppressed repeat): no write.
  - break code: no slot write; invalidates `last_make`.
  - the `ext` flag is not stored in slots.
- `E0 E0` or `F0 F0` sequences are idempotent (flag stays set). `E0 F0 xx` gives `ext`=1, `brk`=1.

## Timing
- Reset values: `scancode`=0, `ext`=0, `brk`=0, `code_valid`=0, `frame_err`=0, `slot_we`=0, `slot_data`=0, `busy`=0; state IDLE, `wr_ptr`=0, pend flags 0, `last_make` invalid.
- Edge numbering: edge 0 = start bit, edges 1–8 = data, edge 9 = parity, edge 10 = stop.
- Pulse outputs (`code_valid`, `frame_err`, `slot_we`) are registered at edge 10. They are high from edge 10 until edge 11, then low.
- `code_valid` and `slot_we` assert in the same cycle.
- `busy` rises at edge 0 and falls at edge 10.
- Reset asserted mid-frame: at the next edge, return to IDLE and restore all reset values; the partial frame is lost and no pulse is produced. The resync relies on the line idling high.
- A start bit may be sampled at edge 11; back-to-back frames with no idle edge are supported.

## Test plan
- Frame `1C`, odd parity bit 0, stop 1 → `code_valid` pulse after edge 10, `scancode`=`1C`, `ext`=0, `brk`=0, `slot_we`=`001`, `slot_data`=`1C`.
- Frames `F0`, `1C` → single `code_valid` with `brk`=1, `scancode`=`1C`; `slot_we` stays `000`.
- Frames `E0`, `F0`, `75` → `ext`=1, `brk`=1, `scancode`=`75`; pend flags cleared afterwards.
- Make codes `1C`, `1C`, `32`, `21`, `23` with `IGNORE_REPEAT`=1 → `slot_we` sequence `001`, (none), `010`, `100`, `001`; `slot_data` `1C`, `32`, `21`, `23`.
- Frame `1C` with parity bit 1 → `frame_err` pulse, no `code_valid`, `scancode` unchanged. Repeat with good parity but stop bit 0 → `frame_err` pulse.
- Reset after edge 5 of a frame, then a full `2B` frame → no pulse from the partial frame; `2B` reported; `slot_we`=`001` (`wr_ptr` reset to 0).
